// File: rtl/mouse_range_ctl_pkg.sv
// mouse_pkg: shared FSM/direction types and 65 MHz timing defaults for mouse_range_ctl.
package mouse_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_REL} state_e;
    typedef enum logic {DIR_UP, DIR_DN} dir_e;
    localparam int HOLD_CYCLES_65M   = 32_500_000;
    localparam int REPEAT_CYCLES_65M = 6_500_000;
endpackage

// File: rtl/mouse_range_ctl_if.sv
// mouse_range_ctl_if: mouse-controller inputs and range-index outputs of mouse_range_ctl.
interface mouse_range_ctl_if #(parameter int IDX_W = 3);
    logic [11:0]      xpos;
    logic             left;
    logic             right;
    logic [IDX_W-1:0] range_idx;
    logic             changed;
    logic             busy;
    modport master (output xpos, left, right, input range_idx, changed, busy);
    modport slave (input xpos, left, right, output range_idx, changed, busy);
endinterface

// File: rtl/mouse_range_ctl_btn_edge.sv
// mouse_btn_edge: registers one button level and flags its rising edge.
module mouse_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic rise_o
);
    logic btn_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) btn_q <= 1'b0;
        else btn_q <= btn_i;
    assign rise_o = btn_i & ~btn_q;
endmodule

// File: rtl/mouse_range_ctl.sv
// mouse_range_ctl: mouse clicks to a range index with hold/auto-repeat and both-button reset.
// Define RANGE_WRAP_EN to make steps wrap around instead of saturating.
module mouse_range_ctl
    import mouse_pkg::*;
#(
    parameter int IDX_W         = 3,
    parameter int MAX_IDX       = 7,
    parameter int DEFAULT_IDX   = 3,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_65M,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_65M,
    parameter int ZONE_LO       = 0,
    parameter int ZONE_HI       = 1023
) (
    input logic             clk,
    input logic             rst,
    mouse_range_ctl_if.slave bus
);
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LD  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [IDX_W-1:0] MAX_V   = IDX_W'(MAX_IDX);
    localparam logic [IDX_W-1:0] DEF_V   = IDX_W'(DEFAULT_IDX);

    state_e           state_q;
    dir_e             dir_q;
    logic [IDX_W-1:0] idx_q, up_v, dn_v, step_d;
    logic [IDX_W:0]   inc_w, dec_w;
    logic [CNT_W-1:0] cnt_q;
    logic             changed_q, rise_l, rise_r, in_zone, act, other_rise;

    mouse_btn_edge u_left  (.clk(clk), .rst(rst), .btn_i(bus.left),  .rise_o(rise_l));
    mouse_btn_edge u_right (.clk(clk), .rst(rst), .btn_i(bus.right), .rise_o(rise_r));

    assign in_zone    = (int'(bus.xpos) >= ZONE_LO) && (int'(bus.xpos) <= ZONE_HI);
    assign inc_w      = {1'b0, idx_q} + (IDX_W+1)'(1);
    assign dec_w      = {1'b0, idx_q} - (IDX_W+1)'(1);
`ifdef RANGE_WRAP_EN
    assign up_v = (idx_q == MAX_V) ? '0 : inc_w[IDX_W-1:0];
    assign dn_v = (idx_q == '0) ? MAX_V : dec_w[IDX_W-1:0];
`else
    assign up_v = (inc_w > {1'b0, MAX_V}) ? MAX_V : inc_w[IDX_W-1:0];
    assign dn_v = dec_w[IDX_W] ? '0 : dec_w[IDX_W-1:0];
`endif
    // In IDLE the direction comes from the fresh edge; afterwards from the latched button.
    assign step_d     = ((state_q == IDLE) ? rise_l : (dir_q == DIR_UP)) ? up_v : dn_v;
    assign act        = (dir_q == DIR_UP) ? bus.left : bus.right;
    assign other_rise = (dir_q == DIR_UP) ? rise_r : rise_l;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q   <= IDLE;
            dir_q     <= DIR_UP;
            idx_q     <= DEF_V;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            changed_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (in_zone && rise_l && rise_r) begin
                        idx_q     <= DEF_V;
                        changed_q <= idx_q != DEF_V;
                        state_q   <= WAIT_REL;
                    end else if (in_zone && (rise_l || rise_r)) begin
                        idx_q     <= step_d;
                        changed_q <= step_d != idx_q;
                        cnt_q     <= HOLD_LD;
                        dir_q     <= rise_l ? DIR_UP : DIR_DN;
                        state_q   <= HOLD;
                    end
                HOLD, REPEAT:
                    if (!act) state_q <= IDLE;
                    else if (other_rise) state_q <= WAIT_REL;
                    else if (cnt_q == '0) begin
                        idx_q     <= step_d;
                        changed_q <= step_d != idx_q;
                        cnt_q     <= REP_LD;
                        state_q   <= REPEAT;
                    end else cnt_q <= cnt_q - 1'b1;
                WAIT_REL:
                    if (!bus.left && !bus.right) state_q <= IDLE;
            endcase
        end

    assign bus.range_idx = idx_q;
    assign bus.changed   = changed_q;
    assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_mouse_range_ctl.sv
// tb_mouse_range_ctl: directed checks of mouse_range_ctl; honours RANGE_WRAP_EN.
module tb_mouse_range_ctl;
`ifdef RANGE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passes = 0;
    int   total = 0;
    int   e, ne;
    bit   stp;

    always #5 clk = ~clk;

    mouse_range_ctl_if #(.IDX_W(3)) bus ();

    mouse_range_ctl #(
        .IDX_W(3), .MAX_IDX(7), .DEFAULT_IDX(3), .HOLD_CYCLES(10), .REPEAT_CYCLES(4),
        .ZONE_LO(100), .ZONE_HI(500)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic click(input bit l, input bit r);
        bus.left = l;
        bus.right = r;
        tick();
        bus.left = 1'b0;
        bus.right = 1'b0;
        tick();
    endtask

    initial begin
        bus.xpos = 12'd200;
        bus.left = 1'b0;
        bus.right = 1'b0;
        tick();
        tick();
        chk("rst_idx", bus.range_idx, 3);
        rst = 1'b1;
        repeat (5) tick();
        chk("idle_idx", bus.range_idx, 3);
        chk("idle_chg", bus.changed, 0);
        chk("idle_busy", bus.busy, 0);

        bus.left = 1'b1;
        tick();
        chk("pulse_idx", bus.range_idx, 4);
        chk("pulse_chg", bus.changed, 1);
        chk("pulse_busy", bus.busy, 1);
        tick();
        chk("pulse_chg2", bus.changed, 0);
        bus.left = 1'b0;
        tick();
        chk("pulse_rel_busy", bus.busy, 0);
        chk("pulse_rel_idx", bus.range_idx, 4);

        click(1'b0, 1'b1);
        chk("back_to_3", bus.range_idx, 3);

        e = 3;
        bus.left = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            stp = (i == 1) || (i >= 11 && (i - 11) % 4 == 0);
            ne = e;
            if (stp) ne = WRAP ? (e + 1) % 8 : (e < 7 ? e + 1 : 7);
            chk("hold_idx", bus.range_idx, ne);
            chk("hold_chg", bus.changed, ne != e);
            e = ne;
        end
        chk("hold_busy", bus.busy, 1);
        bus.left = 1'b0;
        tick();
        chk("hold_rel_busy", bus.busy, 0);
        chk("hold_final", bus.range_idx, WRAP ? 1 : 7);

        repeat (WRAP ? 3 : 1) click(1'b0, 1'b1);
        chk("at_6", bus.range_idx, 6);
        bus.left = 1'b1;
        bus.right = 1'b1;
        tick();
        chk("both_idx", bus.range_idx, 3);
        chk("both_chg", bus.changed, 1);
        repeat (20) tick();
        chk("both_hold_idx", bus.range_idx, 3);
        chk("both_hold_chg", bus.changed, 0);
        chk("both_hold_busy", bus.busy, 1);
        bus.left = 1'b0;
        tick();
        chk("both_half_busy", bus.busy, 1);
        bus.right = 1'b0;
        tick();
        chk("both_rel_busy", bus.busy, 0);
        chk("both_rel_idx", bus.range_idx, 3);

        bus.xpos = 12'd600;
        bus.left = 1'b1;
        tick();
        chk("oz_idx", bus.range_idx, 3);
        chk("oz_chg", bus.changed, 0);
        chk("oz_busy", bus.busy, 0);
        bus.left = 1'b0;
        tick();
        bus.xpos = 12'd500;
        bus.right = 1'b1;
        tick();
        chk("edge_zone_idx", bus.range_idx, 2);
        chk("edge_zone_chg", bus.changed, 1);
        bus.right = 1'b0;
        tick();
        click(1'b0, 1'b1);
        click(1'b0, 1'b1);
        chk("at_0", bus.range_idx, 0);
        bus.right = 1'b1;
        tick();
        chk("floor_idx", bus.range_idx, WRAP ? 7 : 0);
        chk("floor_chg", bus.changed, WRAP ? 1 : 0);
        bus.right = 1'b0;
        tick();

        bus.xpos = 12'd200;
        bus.left = 1'b1;
        repeat (12) tick();
        chk("rep_busy", bus.busy, 1);
        rst = 1'b0;
        #1;
        chk("arst_idx", bus.range_idx, 3);
        chk("arst_busy", bus.busy, 0);
        chk("arst_chg", bus.changed, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        chk("post_rst_idx", bus.range_idx, 4);
        chk("post_rst_chg", bus.changed, 1);
        repeat (3) tick();
        chk("post_rst_idx2", bus.range_idx, 4);
        chk("post_rst_chg2", bus.changed, 0);
        bus.left = 1'b0;
        tick();
        chk("end_busy", bus.busy, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
